// File: rtl/pixel_pkg.sv
// Shared constants and types for the display-side pixel stage and its mean divider.
package pixel_pkg;

    typedef enum logic [1:0] {
        MODE_RGB     = 2'd0,
        MODE_GRAY    = 2'd1,
        MODE_BIN     = 2'd2,
        MODE_BIN_INV = 2'd3
    } pix_mode_e;

    // Luma weights sum to 256 so that gray = weighted sum >> 8 stays in range for equal channels.
    localparam int unsigned W_R_DEF        = 77;
    localparam int unsigned W_G_DEF        = 150;
    localparam int unsigned W_B_DEF        = 29;
    localparam int unsigned LUMA_SHIFT     = 8;
    localparam int unsigned THRESH_DEFAULT = 512;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } div_state_e;

endpackage

// File: rtl/pixel_mode_pipe_if.sv
// Pixel stream bundle between the SDRAM read side and the VGA controller.
interface pixel_mode_pipe_if #(
    parameter int unsigned DATA_W = 10
);
    logic              iDVAL;
    logic              iSOF;
    logic              iEOF;
    logic [DATA_W-1:0] iRed;
    logic [DATA_W-1:0] iGreen;
    logic [DATA_W-1:0] iBlue;
    logic [1:0]        iMODE;
    logic              iAUTO;
    logic [DATA_W-1:0] iTHRESH;
    logic              oDVAL;
    logic [DATA_W-1:0] oRed;
    logic [DATA_W-1:0] oGreen;
    logic [DATA_W-1:0] oBlue;
    logic [DATA_W-1:0] oTHRESH;
    logic              oBUSY;

    modport master (
        output iDVAL, iSOF, iEOF, iRed, iGreen, iBlue, iMODE, iAUTO, iTHRESH,
        input  oDVAL, oRed, oGreen, oBlue, oTHRESH, oBUSY
    );

    modport slave (
        input  iDVAL, iSOF, iEOF, iRed, iGreen, iBlue, iMODE, iAUTO, iTHRESH,
        output oDVAL, oRed, oGreen, oBlue, oTHRESH, oBUSY
    );
endinterface

// File: rtl/frame_mean_div.sv
// Restoring sequential divider, one quotient bit per cycle; used for the per-frame mean gray level.
module frame_mean_div
    import pixel_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = 29,
    parameter int unsigned DIVISOR_W  = 19
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quotient_o
);
    localparam int unsigned STEP_W = $clog2(DIVIDEND_W + 1);

    div_state_e            state_q, state_d;
    logic [DIVISOR_W-1:0]  div_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [STEP_W-1:0]     step_q;
    logic [DIVISOR_W:0]    trial;
    logic                  fits;
    logic                  last_step;

    assign last_step  = (step_q == STEP_W'(DIVIDEND_W - 1));
    assign quotient_o = quo_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero divisor never leaves idle, so the caller's result register is left untouched.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i && (divisor_i != '0)) state_d = StRun;
            StRun:   if (last_step) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q == StRun) || (state_q == StDone);
        done_o = (state_q == StDone);
    end

    always_comb begin
        trial = {rem_q, quo_q[DIVIDEND_W-1]};
        fits  = (trial >= {1'b0, div_q});
    end

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
        end else if ((state_q == StIdle) && start_i) begin
            div_q  <= divisor_i;
            rem_q  <= '0;
            quo_q  <= dividend_i;
            step_q <= '0;
        end else if (state_q == StRun) begin
            rem_q  <= DIVISOR_W'(fits ? (trial - {1'b0, div_q}) : trial);
            quo_q  <= {quo_q[DIVIDEND_W-2:0], fits};
            step_q <= step_q + STEP_W'(1);
        end
    end

endmodule

// File: rtl/pixel_mode_pipe.sv
// Three-stage RGB/gray/binary pixel stage with per-frame mode and threshold; auto threshold is
// the previous frame's mean gray level.
module pixel_mode_pipe
    import pixel_pkg::*;
#(
    parameter int unsigned DATA_W         = 10,
    parameter int unsigned PIX_CNT_W      = 19,
    parameter int unsigned W_R            = pixel_pkg::W_R_DEF,
    parameter int unsigned W_G            = pixel_pkg::W_G_DEF,
    parameter int unsigned W_B            = pixel_pkg::W_B_DEF,
    parameter int unsigned THRESH_DEFAULT = pixel_pkg::THRESH_DEFAULT
) (
    input logic              iCLK,
    input logic              iRST_N,
    pixel_mode_pipe_if.slave pix
);
    localparam int unsigned PROD_W = DATA_W + 8;
    localparam int unsigned SUM_W  = DATA_W + 10;
    localparam int unsigned GRAY_W = SUM_W - LUMA_SHIFT;
    localparam int unsigned ACC_W  = DATA_W + PIX_CNT_W;
    localparam logic [DATA_W-1:0] THR_RST = DATA_W'(THRESH_DEFAULT);

    logic              s1_val_q, s1_sof_q, s1_eof_q;
    logic [DATA_W-1:0] s1_r_q, s1_g_q, s1_b_q, s1_thr_q;
    logic [PROD_W-1:0] s1_pr_q, s1_pg_q, s1_pb_q;
    pix_mode_e         s1_mode_q;

    logic              s2_val_q, s2_sof_q, s2_eof_q;
    logic [DATA_W-1:0] s2_r_q, s2_g_q, s2_b_q, s2_gray_q, s2_thr_q;
    pix_mode_e         s2_mode_q;
    logic [GRAY_W-1:0] gray_full;
    logic [DATA_W-1:0] gray_sat;

    logic              out_val_q;
    logic [DATA_W-1:0] out_r_q, out_g_q, out_b_q, out_thr_q;
    logic [DATA_W-1:0] out_r_d, out_g_d, out_b_d;
    logic [DATA_W-1:0] bin_pix;

    logic [ACC_W-1:0]     sum_q, sum_d, incl_sum;
    logic [ACC_W:0]       sum_add;
    logic [PIX_CNT_W-1:0] cnt_q, cnt_d, incl_cnt;
    logic [DATA_W-1:0]    mean_q;
    logic                 div_start, div_busy, div_done;
    logic [ACC_W-1:0]     div_quo;

    // Mode and threshold only load on an SOF pixel and then ride along with the frame's pixels.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_val_q  <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_eof_q  <= 1'b0;
            s1_r_q    <= '0;
            s1_g_q    <= '0;
            s1_b_q    <= '0;
            s1_pr_q   <= '0;
            s1_pg_q   <= '0;
            s1_pb_q   <= '0;
            s1_mode_q <= MODE_RGB;
            s1_thr_q  <= THR_RST;
        end else begin
            s1_val_q <= pix.iDVAL;
            if (pix.iDVAL) begin
                s1_sof_q <= pix.iSOF;
                s1_eof_q <= pix.iEOF;
                s1_r_q   <= pix.iRed;
                s1_g_q   <= pix.iGreen;
                s1_b_q   <= pix.iBlue;
                s1_pr_q  <= PROD_W'(W_R) * PROD_W'(pix.iRed);
                s1_pg_q  <= PROD_W'(W_G) * PROD_W'(pix.iGreen);
                s1_pb_q  <= PROD_W'(W_B) * PROD_W'(pix.iBlue);
                if (pix.iSOF) begin
                    s1_mode_q <= pix_mode_e'(pix.iMODE);
                    s1_thr_q  <= pix.iAUTO ? mean_q : pix.iTHRESH;
                end
            end
        end
    end

    always_comb begin
        gray_full = GRAY_W'((SUM_W'(s1_pr_q) + SUM_W'(s1_pg_q) + SUM_W'(s1_pb_q)) >> LUMA_SHIFT);
        gray_sat  = (|gray_full[GRAY_W-1:DATA_W]) ? '1 : gray_full[DATA_W-1:0];
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s2_val_q  <= 1'b0;
            s2_sof_q  <= 1'b0;
            s2_eof_q  <= 1'b0;
            s2_r_q    <= '0;
            s2_g_q    <= '0;
            s2_b_q    <= '0;
            s2_gray_q <= '0;
            s2_mode_q <= MODE_RGB;
            s2_thr_q  <= THR_RST;
        end else begin
            s2_val_q <= s1_val_q;
            if (s1_val_q) begin
                s2_sof_q  <= s1_sof_q;
                s2_eof_q  <= s1_eof_q;
                s2_r_q    <= s1_r_q;
                s2_g_q    <= s1_g_q;
                s2_b_q    <= s1_b_q;
                s2_gray_q <= gray_sat;
                s2_mode_q <= s1_mode_q;
                s2_thr_q  <= s1_thr_q;
            end
        end
    end

    always_comb begin
        bin_pix = {DATA_W{s2_gray_q >= s2_thr_q}};
        unique case (s2_mode_q)
            MODE_GRAY: begin
                out_r_d = s2_gray_q;
                out_g_d = s2_gray_q;
                out_b_d = s2_gray_q;
            end
            MODE_BIN: begin
                out_r_d = bin_pix;
                out_g_d = bin_pix;
                out_b_d = bin_pix;
            end
            MODE_BIN_INV: begin
                out_r_d = ~bin_pix;
                out_g_d = ~bin_pix;
                out_b_d = ~bin_pix;
            end
            default: begin
                out_r_d = s2_r_q;
                out_g_d = s2_g_q;
                out_b_d = s2_b_q;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            out_val_q <= 1'b0;
            out_r_q   <= '0;
            out_g_q   <= '0;
            out_b_q   <= '0;
            out_thr_q <= THR_RST;
        end else begin
            out_val_q <= s2_val_q;
            if (s2_val_q) begin
                out_r_q   <= out_r_d;
                out_g_q   <= out_g_d;
                out_b_q   <= out_b_d;
                out_thr_q <= s2_thr_q;
            end
        end
    end

    // incl_* is the running total including the current S2 pixel; an SOF pixel restarts it.
    always_comb begin
        sum_add  = {1'b0, sum_q} + (ACC_W + 1)'(s2_gray_q);
        incl_sum = sum_add[ACC_W] ? '1 : sum_add[ACC_W-1:0];
        incl_cnt = (&cnt_q) ? cnt_q : (cnt_q + PIX_CNT_W'(1));
        if (s2_sof_q) begin
            incl_sum = ACC_W'(s2_gray_q);
            incl_cnt = PIX_CNT_W'(1);
        end
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (s2_val_q) begin
            sum_d = s2_eof_q ? '0 : incl_sum;
            cnt_d = s2_eof_q ? '0 : incl_cnt;
        end
    end

    assign div_start = s2_val_q && s2_eof_q && !div_busy;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sum_q  <= '0;
            cnt_q  <= '0;
            mean_q <= THR_RST;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            if (div_done) begin
                mean_q <= (|div_quo[ACC_W-1:DATA_W]) ? '1 : div_quo[DATA_W-1:0];
            end
        end
    end

    frame_mean_div #(
        .DIVIDEND_W(ACC_W),
        .DIVISOR_W (PIX_CNT_W)
    ) u_mean_div (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .start_i   (div_start),
        .dividend_i(incl_sum),
        .divisor_i (incl_cnt),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quotient_o(div_quo)
    );

    assign pix.oDVAL   = out_val_q;
    assign pix.oRed    = out_r_q;
    assign pix.oGreen  = out_g_q;
    assign pix.oBlue   = out_b_q;
    assign pix.oTHRESH = out_thr_q;
    assign pix.oBUSY   = div_busy;

endmodule

// File: tb/tb_pixel_mode_pipe.sv
// Directed bench for pixel_mode_pipe: outputs are logged per cycle and checked against
// hand-computed values at drive cycle + 3.
module tb_pixel_mode_pipe;
    localparam int unsigned DW   = 10;
    localparam int unsigned HIST = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_mode_pipe_if #(.DATA_W(DW)) pif ();

    pixel_mode_pipe #(
        .DATA_W   (DW),
        .PIX_CNT_W(19)
    ) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .pix   (pif)
    );

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    logic [3*DW:0] h_pix  [0:HIST-1];
    logic [DW-1:0] h_thr  [0:HIST-1];
    logic          h_busy [0:HIST-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < HIST) begin
            h_pix[cyc]  = {pif.oDVAL, pif.oRed, pif.oGreen, pif.oBlue};
            h_thr[cyc]  = pif.oTHRESH;
            h_busy[cyc] = pif.oBUSY;
        end
    end

    function automatic logic [3*DW:0] pk(input logic v, input int r, input int g, input int b);
        return {v, DW'(r), DW'(g), DW'(b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pif.iDVAL = 1'b0;
        pif.iSOF  = 1'b0;
        pif.iEOF  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive(input logic sof, input logic eof, input int r, input int g, input int b,
                         output int stamp);
        stamp      = cyc;
        pif.iDVAL  = 1'b1;
        pif.iSOF   = sof;
        pif.iEOF   = eof;
        pif.iRed   = DW'(r);
        pif.iGreen = DW'(g);
        pif.iBlue  = DW'(b);
        tick();
    endtask

    task automatic settings(input int mode, input logic auto_thr, input int thr);
        pif.iMODE   = 2'(mode);
        pif.iAUTO   = auto_thr;
        pif.iTHRESH = DW'(thr);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        settings(0, 1'b0, 512);
        idle(0);
        pif.iRed = '0; pif.iGreen = '0; pif.iBlue = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++; if (pif.oDVAL !== 1'b0) begin
            n_err++; $display("FAIL rst_dval: got %b want 0", pif.oDVAL);
        end
        n_vec++; if ({pif.oRed, pif.oGreen, pif.oBlue} !== '0) begin
            n_err++; $display("FAIL rst_rgb: got %h want 0", {pif.oRed, pif.oGreen, pif.oBlue});
        end
        n_vec++; if (pif.oTHRESH !== DW'(512)) begin
            n_err++; $display("FAIL rst_thresh: got %0d want 512", pif.oTHRESH);
        end
        n_vec++; if (pif.oBUSY !== 1'b0) begin
            n_err++; $display("FAIL rst_busy: got %b want 0", pif.oBUSY);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        int c0, c1;
        logic [3*DW:0] want;
        settings(0, 1'b0, 512);
        drive(1'b1, 1'b0, 123, 456, 789, c0);
        idle(1);
        drive(1'b0, 1'b0, 5, 6, 7, c1);
        idle(6);
        n_vec++; if (h_pix[c0+2][3*DW] !== 1'b0) begin
            n_err++; $display("FAIL pass_early: dval got %b want 0", h_pix[c0+2][3*DW]);
        end
        want = pk(1'b1, 123, 456, 789);
        n_vec++; if (h_pix[c0+3] !== want) begin
            n_err++; $display("FAIL pass_pix0: got %h want %h", h_pix[c0+3], want);
        end
        want = pk(1'b0, 123, 456, 789);
        n_vec++; if (h_pix[c0+4] !== want) begin
            n_err++; $display("FAIL pass_bubble: got %h want %h", h_pix[c0+4], want);
        end
        want = pk(1'b1, 5, 6, 7);
        n_vec++; if (h_pix[c1+3] !== want) begin
            n_err++; $display("FAIL pass_pix1: got %h want %h", h_pix[c1+3], want);
        end
    endtask

    task automatic test_gray();
        int st [3];
        int rgb [3][3] = '{'{1023, 1023, 1023}, '{0, 0, 0}, '{100, 200, 300}};
        int exp_g [3] = '{1023, 0, 181};
        logic [3*DW:0] want;
        settings(1, 1'b0, 512);
        for (int i = 0; i < 3; i++) drive(i == 0, 1'b0, rgb[i][0], rgb[i][1], rgb[i][2], st[i]);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            want = pk(1'b1, exp_g[i], exp_g[i], exp_g[i]);
            n_vec++; if (h_pix[st[i]+3] !== want) begin
                n_err++; $display("FAIL gray_%0d: got %h want %h", i, h_pix[st[i]+3], want);
            end
        end
    endtask

    task automatic test_binary();
        int st [6];
        int gv [6] = '{511, 512, 511, 512, 512, 700};
        int exp_v [6] = '{0, 1023, 1023, 0, 0, 1023};
        int exp_t [6] = '{512, 512, 512, 512, 600, 600};
        logic [3*DW:0] want;
        settings(2, 1'b0, 512);
        drive(1'b1, 1'b0, gv[0], gv[0], gv[0], st[0]);
        drive(1'b0, 1'b0, gv[1], gv[1], gv[1], st[1]);
        idle(2);
        settings(3, 1'b0, 512);
        drive(1'b1, 1'b0, gv[2], gv[2], gv[2], st[2]);
        drive(1'b0, 1'b0, gv[3], gv[3], gv[3], st[3]);
        settings(2, 1'b0, 600);
        drive(1'b1, 1'b0, gv[4], gv[4], gv[4], st[4]);
        drive(1'b0, 1'b0, gv[5], gv[5], gv[5], st[5]);
        idle(6);
        for (int i = 0; i < 6; i++) begin
            want = pk(1'b1, exp_v[i], exp_v[i], exp_v[i]);
            n_vec++; if (h_pix[st[i]+3] !== want) begin
                n_err++; $display("FAIL bin_pix%0d: got %h want %h", i, h_pix[st[i]+3], want);
            end
            n_vec++; if (h_thr[st[i]+3] !== DW'(exp_t[i])) begin
                n_err++; $display("FAIL bin_thr%0d: got %0d want %0d", i, h_thr[st[i]+3], exp_t[i]);
            end
        end
    endtask

    task automatic test_auto_mean();
        int st, e, s, nb;
        logic [3*DW:0] want;
        pulse_reset();
        settings(2, 1'b0, 512);
        drive(1'b1, 1'b0, 100, 100, 100, st);
        drive(1'b0, 1'b0, 200, 200, 200, st);
        drive(1'b0, 1'b0, 300, 300, 300, st);
        drive(1'b0, 1'b1, 400, 400, 400, e);
        idle(32);
        settings(2, 1'b1, 0);
        drive(1'b1, 1'b0, 250, 250, 250, s);
        drive(1'b0, 1'b0, 249, 249, 249, st);
        idle(6);
        nb = 0;
        for (int i = e; i <= e + 40; i++) nb += int'(h_busy[i]);
        n_vec++; if (nb != 30) begin
            n_err++; $display("FAIL auto_busy_len: got %0d cycles want 30", nb);
        end
        n_vec++; if ({h_busy[e+2], h_busy[e+3], h_busy[e+32], h_busy[e+33]} !== 4'b0110) begin
            n_err++; $display("FAIL auto_busy_edges: got %b want 0110",
                              {h_busy[e+2], h_busy[e+3], h_busy[e+32], h_busy[e+33]});
        end
        n_vec++; if (h_thr[s+2] !== DW'(512)) begin
            n_err++; $display("FAIL auto_thr_before: got %0d want 512", h_thr[s+2]);
        end
        n_vec++; if (h_thr[s+3] !== DW'(250)) begin
            n_err++; $display("FAIL auto_thr: got %0d want 250", h_thr[s+3]);
        end
        want = pk(1'b1, 1023, 1023, 1023);
        n_vec++; if (h_pix[s+3] !== want) begin
            n_err++; $display("FAIL auto_pix250: got %h want %h", h_pix[s+3], want);
        end
        want = pk(1'b1, 0, 0, 0);
        n_vec++; if (h_pix[s+4] !== want) begin
            n_err++; $display("FAIL auto_pix249: got %h want %h", h_pix[s+4], want);
        end
    endtask

    task automatic test_short_blanking();
        int st, e, s1, s3;
        logic [3*DW:0] want;
        pulse_reset();
        settings(2, 1'b0, 512);
        drive(1'b1, 1'b0, 100, 100, 100, st);
        drive(1'b0, 1'b0, 200, 200, 200, st);
        drive(1'b0, 1'b0, 300, 300, 300, st);
        drive(1'b0, 1'b1, 400, 400, 400, e);
        idle(4);
        settings(2, 1'b1, 0);
        drive(1'b1, 1'b0, 300, 300, 300, s1);
        drive(1'b0, 1'b0, 900, 900, 900, st);
        drive(1'b0, 1'b1, 900, 900, 900, st);
        idle(60);
        drive(1'b1, 1'b0, 260, 260, 260, s3);
        drive(1'b0, 1'b0, 240, 240, 240, st);
        idle(6);
        n_vec++; if (h_busy[e+5] !== 1'b1) begin
            n_err++; $display("FAIL short_busy_at_sof: got %b want 1", h_busy[e+5]);
        end
        n_vec++; if (h_thr[s1+3] !== DW'(512)) begin
            n_err++; $display("FAIL short_thr_old: got %0d want 512", h_thr[s1+3]);
        end
        want = pk(1'b1, 0, 0, 0);
        n_vec++; if (h_pix[s1+3] !== want) begin
            n_err++; $display("FAIL short_pix300: got %h want %h", h_pix[s1+3], want);
        end
        want = pk(1'b1, 1023, 1023, 1023);
        n_vec++; if (h_pix[s1+4] !== want) begin
            n_err++; $display("FAIL short_pix900: got %h want %h", h_pix[s1+4], want);
        end
        n_vec++; if (h_thr[s3+3] !== DW'(250)) begin
            n_err++; $display("FAIL short_thr_next: got %0d want 250", h_thr[s3+3]);
        end
        n_vec++; if (h_pix[s3+3] !== want) begin
            n_err++; $display("FAIL short_pix260: got %h want %h", h_pix[s3+3], want);
        end
        want = pk(1'b1, 0, 0, 0);
        n_vec++; if (h_pix[s3+4] !== want) begin
            n_err++; $display("FAIL short_pix240: got %h want %h", h_pix[s3+4], want);
        end
    endtask

    task automatic test_midframe_reset();
        int a, e, p, q0, q1;
        logic [3*DW:0] want;
        settings(1, 1'b0, 512);
        drive(1'b1, 1'b0, 700, 700, 700, a);
        settings(2, 1'b0, 0);
        drive(1'b0, 1'b1, 700, 700, 700, e);
        idle(4);
        want = pk(1'b1, 700, 700, 700);
        n_vec++; if (h_pix[a+3] !== want) begin
            n_err++; $display("FAIL mid_pix0: got %h want %h", h_pix[a+3], want);
        end
        n_vec++; if (h_pix[e+3] !== want) begin
            n_err++; $display("FAIL mid_mode_ignored: got %h want %h", h_pix[e+3], want);
        end
        n_vec++; if (h_busy[e+4] !== 1'b1) begin
            n_err++; $display("FAIL mid_busy_run: got %b want 1", h_busy[e+4]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (pif.oBUSY !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_busy: got %b want 0", pif.oBUSY);
        end
        n_vec++; if ({pif.oDVAL, pif.oRed, pif.oGreen, pif.oBlue} !== '0) begin
            n_err++; $display("FAIL mid_rst_out: got %h want 0",
                              {pif.oDVAL, pif.oRed, pif.oGreen, pif.oBlue});
        end
        n_vec++; if (pif.oTHRESH !== DW'(512)) begin
            n_err++; $display("FAIL mid_rst_thr: got %0d want 512", pif.oTHRESH);
        end
        tick();
        rst_n = 1'b1;
        tick();
        settings(1, 1'b1, 0);
        drive(1'b0, 1'b0, 10, 20, 30, p);
        idle(2);
        settings(2, 1'b1, 0);
        drive(1'b1, 1'b0, 511, 511, 511, q0);
        drive(1'b0, 1'b0, 512, 512, 512, q1);
        idle(6);
        want = pk(1'b1, 10, 20, 30);
        n_vec++; if (h_pix[p+3] !== want) begin
            n_err++; $display("FAIL post_rst_mode0: got %h want %h", h_pix[p+3], want);
        end
        n_vec++; if (h_thr[q0+3] !== DW'(512)) begin
            n_err++; $display("FAIL post_rst_mean: got %0d want 512", h_thr[q0+3]);
        end
        want = pk(1'b1, 0, 0, 0);
        n_vec++; if (h_pix[q0+3] !== want) begin
            n_err++; $display("FAIL post_rst_pix511: got %h want %h", h_pix[q0+3], want);
        end
        want = pk(1'b1, 1023, 1023, 1023);
        n_vec++; if (h_pix[q1+3] !== want) begin
            n_err++; $display("FAIL post_rst_pix512: got %h want %h", h_pix[q1+3], want);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_gray();
        test_binary();
        test_auto_mean();
        test_short_blanking();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
